// File: rtl/tt_um_jleugeri_ttt_token_accumulator.sv
// Per-processor token bank.
// Accumulates saturating good/bad counts from the connection network.
// On batch_done, scans every processor in index order and emits start/stop
// events for those whose activity condition changed since the last scan.
module tt_um_jleugeri_ttt_token_accumulator #(
    parameter int NUM_PROCESSORS  = 8,
    parameter int NEW_TOKENS_BITS = 4,
    parameter int COUNT_BITS      = 8,
    parameter int GOOD_THRESHOLD  = 4,
    parameter int BAD_THRESHOLD   = 2,
    localparam int ID_BITS        = $clog2(NUM_PROCESSORS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid_in,
    input  logic [ID_BITS-1:0]                target_id,
    input  logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens,
    input  logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens,
    input  logic                              batch_done,
    output logic                              ready,
    output logic                              event_valid,
    output logic [ID_BITS-1:0]                event_id,
    output logic [1:0]                        event_startstop,
    output logic                              scan_done,
    output logic                              dropped
);

    // Two spare bits: one so MAX + positive delta cannot wrap, one for the sign.
    localparam int SUM_BITS = COUNT_BITS + 2;
    localparam logic [COUNT_BITS-1:0]      MAX_COUNT = '1;
    localparam logic signed [SUM_BITS-1:0] MAX_SUM   = {2'b00, MAX_COUNT};
    localparam logic [ID_BITS:0]           NUM_ID    = (ID_BITS + 1)'(NUM_PROCESSORS);
    localparam logic [ID_BITS-1:0]         LAST_ID   = ID_BITS'(NUM_PROCESSORS - 1);
    localparam logic [COUNT_BITS:0]        GOOD_TH   = (COUNT_BITS + 1)'(GOOD_THRESHOLD);
    localparam logic [COUNT_BITS:0]        BAD_TH    = (COUNT_BITS + 1)'(BAD_THRESHOLD);

    localparam logic [1:0] EV_NONE  = 2'b00;
    localparam logic [1:0] EV_START = 2'b01;
    localparam logic [1:0] EV_STOP  = 2'b10;

    typedef enum logic {
        ACCUM = 1'b0,
        SCAN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [COUNT_BITS-1:0] good_q [NUM_PROCESSORS];
    logic [COUNT_BITS-1:0] good_d [NUM_PROCESSORS];
    logic [COUNT_BITS-1:0] bad_q  [NUM_PROCESSORS];
    logic [COUNT_BITS-1:0] bad_d  [NUM_PROCESSORS];
    logic [NUM_PROCESSORS-1:0] active_q, active_d;

    logic [ID_BITS-1:0] scan_idx_q, scan_idx_d;
    logic               event_valid_q, event_valid_d;
    logic [ID_BITS-1:0] event_id_q, event_id_d;
    logic [1:0]         event_startstop_q, event_startstop_d;
    logic               scan_done_q, scan_done_d;
    logic               dropped_q, dropped_d;
    logic               scan_cond;

    // Add a signed delta to an unsigned count, clamping into [0, MAX].
    function automatic logic [COUNT_BITS-1:0] sat_add(
        input logic [COUNT_BITS-1:0]             count,
        input logic signed [NEW_TOKENS_BITS-1:0] delta
    );
        logic signed [SUM_BITS-1:0] sum;
        sum = $signed({2'b00, count})
            + $signed({{(SUM_BITS - NEW_TOKENS_BITS){delta[NEW_TOKENS_BITS-1]}}, delta});
        if (sum < 0) begin
            sat_add = '0;
        end else if (sum > MAX_SUM) begin
            sat_add = MAX_COUNT;
        end else begin
            sat_add = sum[COUNT_BITS-1:0];
        end
    endfunction

    // State register and all datapath flops; reset also aborts a scan in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ACCUM;
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
                good_q[i] <= '0;
                bad_q[i]  <= '0;
            end
            active_q          <= '0;
            scan_idx_q        <= '0;
            event_valid_q     <= 1'b0;
            event_id_q        <= '0;
            event_startstop_q <= EV_NONE;
            scan_done_q       <= 1'b0;
            dropped_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            good_q            <= good_d;
            bad_q             <= bad_d;
            active_q          <= active_d;
            scan_idx_q        <= scan_idx_d;
            event_valid_q     <= event_valid_d;
            event_id_q        <= event_id_d;
            event_startstop_q <= event_startstop_d;
            scan_done_q       <= scan_done_d;
            dropped_q         <= dropped_d;
        end
    end

    // Next state: batch_done starts a scan, the last processor ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (batch_done) state_d = SCAN;
            SCAN:    if (scan_idx_q == LAST_ID) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Datapath: apply deltas while accumulating, evaluate one processor per scan cycle.
    always_comb begin
        good_d            = good_q;
        bad_d             = bad_q;
        active_d          = active_q;
        scan_idx_d        = scan_idx_q;
        event_valid_d     = 1'b0;
        event_id_d        = '0;
        event_startstop_d = EV_NONE;
        scan_done_d       = 1'b0;
        dropped_d         = dropped_q;
        scan_cond         = 1'b0;
        case (state_q)
            ACCUM: begin
                if (valid_in && ({1'b0, target_id} < NUM_ID)) begin
                    good_d[target_id] = sat_add(good_q[target_id], new_good_tokens);
                    bad_d[target_id]  = sat_add(bad_q[target_id], new_bad_tokens);
                end
                if (batch_done) begin
                    scan_idx_d = '0;
                end
            end
            SCAN: begin
                if (valid_in || batch_done) begin
                    dropped_d = 1'b1;
                end
                scan_cond = ({1'b0, good_q[scan_idx_q]} >= GOOD_TH)
                         && ({1'b0, bad_q[scan_idx_q]} < BAD_TH);
                if (scan_cond && !active_q[scan_idx_q]) begin
                    event_valid_d        = 1'b1;
                    event_id_d           = scan_idx_q;
                    event_startstop_d    = EV_START;
                    active_d[scan_idx_q] = 1'b1;
                end else if (!scan_cond && active_q[scan_idx_q]) begin
                    event_valid_d        = 1'b1;
                    event_id_d           = scan_idx_q;
                    event_startstop_d    = EV_STOP;
                    active_d[scan_idx_q] = 1'b0;
                end
                if (scan_idx_q == LAST_ID) begin
                    scan_done_d = 1'b1;
                    scan_idx_d  = '0;
                end else begin
                    scan_idx_d  = scan_idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs: ready follows the state, events come straight from their flops.
    always_comb begin
        ready           = (state_q == ACCUM);
        event_valid     = event_valid_q;
        event_id        = event_id_q;
        event_startstop = event_startstop_q;
        scan_done       = scan_done_q;
        dropped         = dropped_q;
    end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_token_accumulator.sv
// Directed bench for the token accumulator: 4 processors, 4-bit counters,
// good threshold 3, bad threshold 2.
module tb_tt_um_jleugeri_ttt_token_accumulator;

    localparam int NP = 4;
    localparam int IB = 2;

    logic              clk;
    logic              reset;
    logic              valid_in;
    logic [IB-1:0]     target_id;
    logic signed [3:0] new_good_tokens;
    logic signed [3:0] new_bad_tokens;
    logic              batch_done;
    logic              ready;
    logic              event_valid;
    logic [IB-1:0]     event_id;
    logic [1:0]        event_startstop;
    logic              scan_done;
    logic              dropped;

    int check_count = 0;
    int pass_count  = 0;

    tt_um_jleugeri_ttt_token_accumulator #(
        .NUM_PROCESSORS (NP),
        .NEW_TOKENS_BITS(4),
        .COUNT_BITS     (4),
        .GOOD_THRESHOLD (3),
        .BAD_THRESHOLD  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .target_id      (target_id),
        .new_good_tokens(new_good_tokens),
        .new_bad_tokens (new_bad_tokens),
        .batch_done     (batch_done),
        .ready          (ready),
        .event_valid    (event_valid),
        .event_id       (event_id),
        .event_startstop(event_startstop),
        .scan_done      (scan_done),
        .dropped        (dropped)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one delta update for a single cycle.
    task automatic applyStimulus(input int id, input int good_delta, input int bad_delta);
        valid_in        = 1'b1;
        target_id       = IB'(id);
        new_good_tokens = 4'(good_delta);
        new_bad_tokens  = 4'(bad_delta);
        tick();
        valid_in        = 1'b0;
        new_good_tokens = '0;
        new_bad_tokens  = '0;
    endtask

    // Request a scan and check every scan cycle; exp_ev packs {id3,id2,id1,id0}
    // event codes. Any valid_in already driven by the caller rides with batch_done.
    // With drop_in set, an update for id3 is offered during the first scan cycle.
    task automatic runScan(input string name, input logic [7:0] exp_ev, input bit drop_in);
        logic [1:0] code;
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        valid_in   = 1'b0;
        checkOutput({name, " ready_low"}, int'(ready), 0);
        if (drop_in) begin
            valid_in        = 1'b1;
            target_id       = IB'(3);
            new_good_tokens = 4'sd7;
            new_bad_tokens  = 4'sd0;
        end
        for (int i = 0; i < NP; i++) begin
            tick();
            valid_in = 1'b0;
            code = exp_ev[2*i +: 2];
            checkOutput($sformatf("%s ev_valid[%0d]", name, i), int'(event_valid), int'(code != 2'b00));
            checkOutput($sformatf("%s ev_ss[%0d]", name, i), int'(event_startstop), int'(code));
            if (code != 2'b00) begin
                checkOutput($sformatf("%s ev_id[%0d]", name, i), int'(event_id), i);
            end
            checkOutput($sformatf("%s scan_done[%0d]", name, i), int'(scan_done), int'(i == NP - 1));
            checkOutput($sformatf("%s ready[%0d]", name, i), int'(ready), int'(i == NP - 1));
        end
    endtask

    // Scenario sequence with expectations derived by hand from the counter state.
    initial begin
        reset           = 1'b1;
        valid_in        = 1'b0;
        target_id       = '0;
        new_good_tokens = '0;
        new_bad_tokens  = '0;
        batch_done      = 1'b0;
        tick();
        tick();
        checkOutput("rst ready", int'(ready), 1);
        checkOutput("rst ev_valid", int'(event_valid), 0);
        checkOutput("rst ev_id", int'(event_id), 0);
        checkOutput("rst ev_ss", int'(event_startstop), 0);
        checkOutput("rst scan_done", int'(scan_done), 0);
        checkOutput("rst dropped", int'(dropped), 0);
        reset = 1'b0;
        tick();

        // Empty bank: a scan produces no events.
        runScan("s1", 8'b00_00_00_00, 1'b0);

        // id2 reaches the good threshold, then exceeds the bad threshold.
        applyStimulus(2, 3, 0);
        runScan("s2a", 8'b00_01_00_00, 1'b0);
        applyStimulus(2, 0, 2);
        runScan("s2b", 8'b00_10_00_00, 1'b0);

        // id1 saturates at 15: 15-7=8 stays active, 8-7=1 stops.
        applyStimulus(1, 7, 0);
        applyStimulus(1, 7, 0);
        applyStimulus(1, 7, 0);
        runScan("s3a", 8'b00_00_01_00, 1'b0);
        applyStimulus(1, -7, 0);
        runScan("s3b", 8'b00_00_00_00, 1'b0);
        applyStimulus(1, -7, 0);
        runScan("s3c", 8'b00_00_10_00, 1'b0);

        // id0 clamps at 0: -8 then +2 gives 2, below threshold.
        applyStimulus(0, -8, 0);
        applyStimulus(0, 2, 0);
        runScan("s3d", 8'b00_00_00_00, 1'b0);

        // Update coinciding with batch_done is visible to that scan: good0 = 5.
        valid_in        = 1'b1;
        target_id       = IB'(0);
        new_good_tokens = 4'sd3;
        new_bad_tokens  = 4'sd0;
        runScan("s4", 8'b00_00_00_01, 1'b0);
        checkOutput("s4 dropped", int'(dropped), 0);

        // Update during a scan is dropped: id3 must not start afterwards.
        runScan("s5a", 8'b00_00_00_00, 1'b1);
        checkOutput("s5 dropped", int'(dropped), 1);
        runScan("s5b", 8'b00_00_00_00, 1'b0);
        checkOutput("s5 dropped sticky", int'(dropped), 1);

        // Pending starts on id2 and id3, reset lands on the second scan cycle.
        applyStimulus(2, 0, -2);
        applyStimulus(3, 4, 0);
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        checkOutput("s6 ready_low", int'(ready), 0);
        tick();
        checkOutput("s6 ev_valid0", int'(event_valid), 0);
        reset = 1'b1;
        tick();
        checkOutput("s6 rst ready", int'(ready), 1);
        checkOutput("s6 rst ev_valid", int'(event_valid), 0);
        checkOutput("s6 rst ev_ss", int'(event_startstop), 0);
        checkOutput("s6 rst ev_id", int'(event_id), 0);
        checkOutput("s6 rst scan_done", int'(scan_done), 0);
        checkOutput("s6 rst dropped", int'(dropped), 0);
        reset = 1'b0;
        for (int i = 0; i < NP; i++) begin
            tick();
            checkOutput($sformatf("s6 quiet ev_valid[%0d]", i), int'(event_valid), 0);
            checkOutput($sformatf("s6 quiet scan_done[%0d]", i), int'(scan_done), 0);
        end
        // id0 was active with good=5: a stale active bit or count would emit here.
        runScan("s6 post", 8'b00_00_00_00, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/tt_um_jleugeri_ttt_token_accumulator.md
# tt_um_jleugeri_ttt_token_accumulator

Per-processor token bank that sits directly downstream of the connection network stage. It consumes the network's stream of `(target_id, new_good_tokens, new_bad_tokens)` updates and keeps saturating good/bad token counts for every processor. When the upstream controller marks a fan-out batch as complete, the block scans all processors in index order. For each processor whose activity condition changed, it emits a start or stop event, encoded in the same `token_startstop` format the network consumes.

## Interface
- `NUM_PROCESSORS`, default 8: number of processors; `ID_BITS = $clog2(NUM_PROCESSORS)`.
- `NEW_TOKENS_BITS`, default 4: width of the signed token deltas.
- `COUNT_BITS`, default 8: width of each unsigned counter; `MAX = 2**COUNT_BITS-1`.
- `GOOD_THRESHOLD`, default 4: a processor is active when `good >= GOOD_THRESHOLD` and `bad < BAD_THRESHOLD`.
- `BAD_THRESHOLD`, default 2: see `GOOD_THRESHOLD`.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `valid_in`  in  1: a delta update is present this cycle.
- `target_id`  in  ID_BITS: processor that receives the deltas.
- `new_good_tokens`  in  NEW_TOKENS_BITS, signed: delta to the good count.
- `new_bad_tokens`  in  NEW_TOKENS_BITS, signed: delta to the bad count.
- `batch_done`  in  1: the current fan-out batch is complete; requests a scan.
- `ready`  out  1: high in ACCUM (updates accepted); low in SCAN.
- `event_valid`  out  1: `event_id`/`event_startstop` are valid this cycle.
- `event_id`  out  ID_BITS: processor whose state changed.
- `event_startstop`  out  2: 2'b01 = start, 2'b10 = stop; 2'b00 when `event_valid` is low.
- `scan_done`  out  1: one-cycle pulse coinciding with the last scan evaluation.
- `dropped`  out  1: sticky flag, set when an update or `batch_done` arrives while `ready` is low; cleared only by reset.

## Operation
- Storage: `good[i]`, `bad[i]` (COUNT_BITS, unsigned) and `active[i]` (1 bit) for each processor.
- Reset:
  - all counters and `active` = 0; state = ACCUM.
  - `ready` = 1; `event_valid`, `event_id`, `event_startstop`, `scan_done`, `dropped` = 0.
  - Reset mid-scan aborts the scan immediately; no further events are emitted.
- State ACCUM:
  - On `valid_in`: `good[target_id] <= sat(good + sext(new_good_tokens))`; same rule for `bad`.
  - Arithmetic is done in COUNT_BITS+2 signed; results below 0 clamp to 0, results above MAX clamp to MAX.
  - A zero delta leaves the count unchanged.
  - `target_id >= NUM_PROCESSORS`: the update is ignored; no flag is raised.
- `valid_in` and `batch_done` in the same ACCUM cycle: the update is applied, then state goes to SCAN. The scan sees the updated value.
- State SCAN:
  - A scan index `s` runs 0..NUM_PROCESSORS-1, one processor per cycle.
  - Compute `cond = good[s] >= GOOD_THRESHOLD && bad[s] < BAD_THRESHOLD`.
  - If `cond && !active[s]`: emit start (01) and set `active[s]`.
  - If `!cond && active[s]`: emit stop (10) and clear `active[s]`.
  - Otherwise `event_valid` = 0 for that cycle.
  - Counters are not cleared by the scan.
  - After `s = NUM_PROCESSORS-1`: `scan_done` pulses and state returns to ACCUM.
- Inputs in SCAN: `valid_in` or `batch_done` is discarded and sets `dropped`. Counters are unaffected.

## Timing
- Update latency: `valid_in` sampled at edge k; the new count is visible to the scan from edge k+1.
- Scan latency:
  - `batch_done` sampled at edge T; state becomes SCAN and `ready` drops after T.
  - Processor i is evaluated at edge T+1+i. Its event outputs are registered there and are high for exactly one cycle.
  - `scan_done` is registered at edge T+NUM_PROCESSORS together with the last evaluation. State returns to ACCUM and `ready` rises at that same edge.
- Throughput:
  - A scan occupies exactly NUM_PROCESSORS cycles.
  - There are at most NUM_PROCESSORS events per scan, in ascending `event_id` order.
  - Back-to-back: `batch_done` asserted in the first cycle `ready` is high again starts a new scan.
- There is no backpressure on the event outputs; the consumer must accept one event per cycle.

## Test plan
Configuration for all scenarios: NUM_PROCESSORS=4, COUNT_BITS=4 (MAX=15), GOOD_THRESHOLD=3, BAD_THRESHOLD=2.

1. Reset, then `batch_done` -> 4 scan cycles with `event_valid` = 0 throughout; `scan_done` pulses at the 4th; `ready` is low for exactly 4 cycles.
2. Updates (id2, +3, 0), then `batch_done` -> a single event (id=2, 01) in scan cycle 3. Then (id2, 0, +2) and `batch_done` -> event (id=2, 10).
3. Saturation: (id1, +7, 0) three times -> good[1] = 15. Then (id0, -8, 0) on a zero count -> good[0] stays 0.
4. `valid_in` (id0, +3, 0) in the same cycle as `batch_done` -> the scan emits (id=0, 01) in its first cycle.
5. `valid_in` during SCAN -> `dropped` = 1; counters unchanged; a later scan reflects no change.
6. Reset asserted in scan cycle 2 with pending changes on ids 2 and 3 -> no events after reset; all outputs 0 and `ready` = 1 on the next cycle; all `active` bits cleared.
